// File: rtl/pipe_ctrl.sv
// Pipeline hazard / memory-wait controller.
// Produces freeze, flush and bubble controls for a 5-stage pipe, sequences
// multi-cycle MEM-stage accesses, and keeps saturating event counters.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal flow; a MEM access freezes the pipe in this same cycle
// MWAIT | access in progress; wcnt counts the remaining freeze cycles
module pipe_ctrl #(
  parameter int unsigned MEM_WAIT = 4,
  parameter bit          FWD_EN   = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_read,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        branch_taken,
  input  logic        mem_req,
  output logic        freeze_if,
  output logic        flush_if,
  output logic        bubble_id,
  output logic        freeze_all,
  output logic        mem_done,
  output logic        state,
  output logic [15:0] hz_cnt,
  output logic [15:0] mw_cnt,
  output logic [15:0] fl_cnt
);

  typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

  // The RUN cycle that accepts the access is the first freeze cycle,
  // so the timer is loaded with one less than the full wait.
  localparam bit          WAIT_EN   = (MEM_WAIT != 0);
  localparam int unsigned WAIT_M1   = WAIT_EN ? MEM_WAIT - 1 : 0;
  localparam logic [3:0]  WAIT_LOAD = WAIT_M1[3:0];

  state_t     st_q;
  logic [3:0] wcnt;
  logic       hazard;
  logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;

  assign state = st_q;

  // Source/destination match; with forwarding only a load in EX can stall.
  always_comb begin
    ex_hit1  = exe_wb_en && (exe_dest == id_src1);
    ex_hit2  = exe_wb_en && (exe_dest == id_src2);
    mem_hit1 = mem_wb_en && (mem_dest == id_src1);
    mem_hit2 = mem_wb_en && (mem_dest == id_src2);
    if (FWD_EN) begin
      hazard = id_valid && exe_mem_read && (ex_hit1 || (id_two_src && ex_hit2));
    end else begin
      hazard = id_valid && (ex_hit1 || mem_hit1 ||
                            (id_two_src && (ex_hit2 || mem_hit2)));
    end
  end

  // Pipeline controls; memory wait dominates, then branch, then hazard.
  always_comb begin
    freeze_all = 1'b0;
    mem_done   = 1'b0;
    if (!RST) begin
      if (st_q == RUN) begin
        if (mem_req) begin
          if (WAIT_EN) freeze_all = 1'b1;
          else         mem_done   = 1'b1;
        end
      end else if (wcnt != 4'd0) begin
        freeze_all = 1'b1;
      end else begin
        mem_done = 1'b1;
      end
    end
    freeze_if = !RST && (freeze_all || (hazard && !branch_taken));
    bubble_id = !RST && !freeze_all && (hazard || branch_taken);
    flush_if  = !RST && !freeze_all && branch_taken;
  end

  // Memory-wait sequencer with its down-counting timer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q <= RUN;
      wcnt <= 4'd0;
    end else begin
      case (st_q)
        RUN: begin
          if (mem_req && WAIT_EN) begin
            wcnt <= WAIT_LOAD;
            st_q <= MWAIT;
          end
        end
        MWAIT: begin
          if (wcnt != 4'd0) wcnt <= wcnt - 4'd1;
          else              st_q <= RUN;
        end
        default: st_q <= RUN;
      endcase
    end
  end

  // Saturating event counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hz_cnt <= 16'd0;
      mw_cnt <= 16'd0;
      fl_cnt <= 16'd0;
    end else begin
      if (freeze_if && !freeze_all && (hz_cnt != 16'hFFFF)) hz_cnt <= hz_cnt + 16'd1;
      if (freeze_all && (mw_cnt != 16'hFFFF))               mw_cnt <= mw_cnt + 16'd1;
      if (flush_if && (fl_cnt != 16'hFFFF))                 fl_cnt <= fl_cnt + 16'd1;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
- REQ-001: Parameters SHALL be:
  - MEM_WAIT, default 4: stall cycles per MEM-stage access, legal range 0..15.
  - FWD_EN, default 0: 1 = forwarding present, so only load-use hazards stall.
- REQ-002: Clock and reset SHALL be `CLK` then `RST`. There is one clock. Reset is synchronous and active-high.
- REQ-003: Ports SHALL be (name, direction, width, meaning):
  - `CLK` in 1: rising-edge clock.
  - `RST` in 1: synchronous active-high reset.
  - `id_valid` in 1: ID holds a real instruction.
  - `id_src1` in 4: ID first source register.
  - `id_src2` in 4: ID second source register.
  - `id_two_src` in 1: `id_src2` is used.
  - `exe_dest` in 4: EX destination register.
  - `exe_wb_en` in 1: EX writes a register.
  - `exe_mem_read` in 1: EX is a load.
  - `mem_dest` in 4: MEM destination register.
  - `mem_wb_en` in 1: MEM writes a register.
  - `branch_taken` in 1: EX resolved a taken branch.
  - `mem_req` in 1: MEM holds a load/store.
  - `freeze_if` out 1: hold PC and IF_Reg.
  - `flush_if` out 1: clear IF_Reg.
  - `bubble_id` out 1: load a NOP into ID_Reg.
  - `freeze_all` out 1: hold ID_Reg, EX_Reg and MEM_Reg.
  - `mem_done` out 1: one-cycle pulse when an access completes.
  - `state` out 1: 0 = RUN, 1 = MWAIT.
  - `hz_cnt` out 16: hazard-stall counter.
  - `mw_cnt` out 16: memory-stall counter.
  - `fl_cnt` out 16: flush counter.

Function
- REQ-004: The FSM SHALL have two states, RUN and MWAIT, plus a 4-bit down-counter `wcnt`.
- REQ-005: In RUN with `mem_req`=1 and MEM_WAIT>0, the block SHALL:
  - assert `freeze_all` in that same cycle;
  - load `wcnt` with MEM_WAIT-1;
  - enter MWAIT on the next edge.
- REQ-006: In MWAIT with `wcnt`!=0, `freeze_all` SHALL be 1 and `wcnt` SHALL decrement each cycle.
- REQ-007: In MWAIT with `wcnt`=0, the block SHALL:
  - drive `freeze_all`=0 and `mem_done`=1;
  - return to RUN on the next edge;
  - not retrigger on `mem_req` in that cycle.
- REQ-008: The total freeze per access SHALL be exactly MEM_WAIT cycles.
- REQ-009: If MEM_WAIT=0, the block SHALL never leave RUN, never assert `freeze_all`, and pulse `mem_done` in every cycle in which `mem_req`=1.
- REQ-010: The `hazard` signal SHALL be computed as follows:
  - With FWD_EN=0: `hazard` = `id_valid` AND (match of `id_src1`, or of `id_src2` when `id_two_src`=1) against (`exe_wb_en` AND `exe_dest`) OR (`mem_wb_en` AND `mem_dest`).
  - With FWD_EN=1: only the EX match qualified by `exe_mem_read` SHALL count.
- REQ-011: The outputs SHALL be combinational functions of the current inputs and state:
  - `freeze_if` = `freeze_all` OR (`hazard` AND NOT `branch_taken`);
  - `bubble_id` = NOT `freeze_all` AND (`hazard` OR `branch_taken`);
  - `flush_if` = NOT `freeze_all` AND `branch_taken`.
- REQ-012: Priority SHALL be memory wait > branch > hazard.
  - A branch seen during `freeze_all` SHALL be suppressed and re-evaluated once the freeze drops.
  - A branch and a hazard in the same cycle SHALL produce a flush only.
- REQ-013: Each counter SHALL increment by 1 per cycle on its condition and saturate at 16'hFFFF:
  - `hz_cnt` on `freeze_if` AND NOT `freeze_all`;
  - `mw_cnt` on `freeze_all`;
  - `fl_cnt` on `flush_if`.

Reset
- REQ-014: With `RST`=1 at an edge, the block SHALL set `state`=RUN, `wcnt`=0 and all counters to 0.
- REQ-015: While `RST`=1, `freeze_if`, `flush_if`, `bubble_id`, `freeze_all` and `mem_done` SHALL be forced to 0.
- REQ-016: A reset asserted mid-MWAIT SHALL abandon the access, with the block in RUN after the edge.

Verification
- REQ-017: The bench SHALL cover these directed scenarios (stimulus -> required response):
  - RAW: FWD_EN=0, `exe_dest`=3, `exe_wb_en`=1, `id_src1`=3, `id_valid`=1 -> `freeze_if`=1, `bubble_id`=1, `flush_if`=0, `hz_cnt` +1.
  - Memory wait: MEM_WAIT=4, `mem_req` held 5 cycles from RUN -> `freeze_all`=1 for 4 cycles, `mem_done` on cycle 5, `mw_cnt`=4, `state` back to 0.
  - Branch during freeze: `branch_taken`=1 while `freeze_all`=1 -> `flush_if`=0; on the first unfrozen cycle `flush_if`=1 and `bubble_id`=1.
  - Forwarding: FWD_EN=1, EX non-load matching `id_src2`, `id_two_src`=1 -> no stall; same case with `exe_mem_read`=1 -> stall.
  - Reset mid-MWAIT: `RST` pulsed at `wcnt`=2 -> next cycle `state`=0, all counters 0, `freeze_all`=0.
  - Saturation: `hz_cnt` preloaded by 65535 hazard cycles plus 1 more -> `hz_cnt` stays 16'hFFFF.
